// File: rtl/btn_uart_pkg.sv
// Shared definitions for the button-to-UART message transmitter.
//   - ASCII constants used to frame the "R<row>C<col>\r\n" message
//   - MSG_LEN: number of bytes per message
//   - state encodings for the byte serializer and the message sequencer
//   - hex2ascii / msg_byte helpers used to build the message bytes
package btn_uart_pkg;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int MSG_LEN = 6;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_e;

  // Uppercase hex digit: '0'..'9' then 'A'..'F' ('A' - 10 == 8'h37).
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte at position idx of the message for key (row, col).
  function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                          input logic [3:0] row,
                                          input logic [3:0] col);
    case (idx)
      3'd0:    return ASCII_R;
      3'd1:    return hex2ascii(row);
      3'd2:    return ASCII_C;
      3'd3:    return hex2ascii(col);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/btn_uart_tx_byte.sv
// uart_byte_tx: 8N1 serializer for one byte per handshake.
//   clk, rst         clock; asynchronous active-low reset
//   byte_valid       a byte is offered on byte_data
//   byte_data [7:0]  byte to send (LSB first)
//   byte_ready       serializer accepts a byte this cycle: either idle, or on
//                    the last cycle of a stop bit so frames chain with no gap
//   tx               registered serial output, idles high
module uart_byte_tx
  import btn_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        r_state,    w_state_nx;
  logic [CNT_W-1:0] r_baud_cnt, w_baud_nx;
  logic [2:0]       r_bit_idx,  w_bit_nx;
  logic [7:0]       r_shift,    w_shift_nx;
  logic             r_tx,       w_tx_nx;
  logic             w_bit_end;

  assign w_bit_end = (r_baud_cnt == LAST_CNT);
  assign tx        = r_tx;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
    w_bit_nx   = r_bit_idx;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    byte_ready = 1'b0;

    case (r_state)
      TX_IDLE: begin
        byte_ready = 1'b1;
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
        if (byte_valid) begin
          w_state_nx = TX_START;
          w_tx_nx    = 1'b0;
          w_shift_nx = byte_data;
          w_bit_nx   = '0;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_state_nx = TX_DATA;
          w_tx_nx    = r_shift[0];
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = '0;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nx = TX_STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx   = r_bit_idx + 3'd1;
            w_tx_nx    = r_shift[0];
            w_shift_nx = r_shift >> 1;
          end
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          // Accepting on the final stop cycle puts the next start bit right
          // after this stop bit.
          byte_ready = 1'b1;
          if (byte_valid) begin
            w_state_nx = TX_START;
            w_tx_nx    = 1'b0;
            w_shift_nx = byte_data;
            w_bit_nx   = '0;
          end else begin
            w_state_nx = TX_IDLE;
          end
        end
      end
      default: w_state_nx = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= TX_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_baud_cnt <= w_baud_nx;
      r_bit_idx  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_tx       <= w_tx_nx;
    end
  end

endmodule

// File: rtl/btn_uart_tx.sv
// btn_uart_tx: turns a key-press request into the ASCII message
// "R<row>C<col>\r\n" sent 8N1 on uart_tx.
//   clk, rst        clock; asynchronous active-low reset
//   tx_start        single-cycle request pulse
//   tx_data0 [3:0]  key row, sampled with tx_start
//   tx_data1 [3:0]  key column, sampled with tx_start
//   uart_tx         serial line to the USB-UART bridge, idles high
//   tx_busy         high while a message is being shifted out
//   tx_dropped      one-cycle pulse when a buffered request is overwritten
// Holds the message sequencer and a one-entry pending buffer; the bit
// timing lives in uart_byte_tx.
module btn_uart_tx
  import btn_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] tx_data0,
  input  logic [3:0] tx_data1,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_dropped
);

  localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_IDX     = 3'(MSG_LEN - 1);

  seq_state_e r_seq,       w_seq_nx;
  logic [2:0] r_byte_idx,  w_idx_nx;
  logic [3:0] r_row,       w_row_nx;
  logic [3:0] r_col,       w_col_nx;
  logic       r_pend_valid, w_pend_v_nx;
  logic [3:0] r_pend_row,  w_pend_row_nx;
  logic [3:0] r_pend_col,  w_pend_col_nx;
  logic       r_dropped,   w_drop;
  logic       w_byte_valid, w_byte_ready, w_chain;
  logic [7:0] w_byte_data;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte_data),
    .byte_ready(w_byte_ready),
    .tx        (uart_tx)
  );

  assign tx_busy    = (r_seq == SEQ_SEND);
  assign tx_dropped = r_dropped;

  always_comb begin
    w_seq_nx      = r_seq;
    w_idx_nx      = r_byte_idx;
    w_row_nx      = r_row;
    w_col_nx      = r_col;
    w_pend_v_nx   = r_pend_valid;
    w_pend_row_nx = r_pend_row;
    w_pend_col_nx = r_pend_col;
    w_drop        = 1'b0;
    w_chain       = 1'b0;
    w_byte_valid  = 1'b0;
    w_byte_data   = ASCII_R;

    case (r_seq)
      SEQ_IDLE: begin
        // Offer the first byte in the request cycle itself so the start bit
        // appears right after the sampling edge.
        if (tx_start) begin
          w_byte_valid = 1'b1;
          w_seq_nx     = SEQ_SEND;
          w_idx_nx     = '0;
          w_row_nx     = tx_data0;
          w_col_nx     = tx_data1;
        end
      end
      SEQ_SEND: begin
        if (w_byte_ready) begin
          if (r_byte_idx != LAST_IDX) begin
            w_byte_valid = 1'b1;
            w_idx_nx     = r_byte_idx + 3'd1;
            w_byte_data  = msg_byte(w_idx_nx, r_row, r_col);
          end else if (r_pend_valid || tx_start) begin
            // Chain the next message; a request arriving right now is the
            // newest and displaces whatever the buffer held.
            w_chain      = 1'b1;
            w_byte_valid = 1'b1;
            w_idx_nx     = '0;
            w_pend_v_nx  = 1'b0;
            w_drop       = tx_start && r_pend_valid;
            w_row_nx     = tx_start ? tx_data0 : r_pend_row;
            w_col_nx     = tx_start ? tx_data1 : r_pend_col;
          end else begin
            w_seq_nx = SEQ_IDLE;
          end
        end
        if (tx_start && !w_chain) begin
          w_pend_v_nx   = 1'b1;
          w_pend_row_nx = tx_data0;
          w_pend_col_nx = tx_data1;
          w_drop        = r_pend_valid;
        end
      end
      default: w_seq_nx = SEQ_IDLE;
    endcase
  end

  // NOTE: the buffered row/col are reset along with the valid flag; it costs
  // nothing here and keeps every register deterministic after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq        <= SEQ_IDLE;
      r_byte_idx   <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_row   <= '0;
      r_pend_col   <= '0;
      r_dropped    <= 1'b0;
    end else begin
      r_seq        <= w_seq_nx;
      r_byte_idx   <= w_idx_nx;
      r_row        <= w_row_nx;
      r_col        <= w_col_nx;
      r_pend_valid <= w_pend_v_nx;
      r_pend_row   <= w_pend_row_nx;
      r_pend_col   <= w_pend_col_nx;
      r_dropped    <= w_drop;
    end
  end

endmodule

// File: tb/tb_btn_uart_tx.sv
// Self-checking bench for btn_uart_tx. A message-level reference model
// (600-cycle messages, one pending slot) pushes expected bytes into a queue
// and tracks expected tx_busy / tx_dropped; a UART receiver decodes uart_tx
// and compares each received byte against the queue.
module tb_btn_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int MSG_CYC  = 60 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_data0 = 4'h0;
  logic [3:0] tx_data1 = 4'h0;
  logic       uart_tx, tx_busy, tx_dropped;

  btn_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data0  (tx_data0),
    .tx_data1  (tx_data1),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .tx_dropped(tx_dropped)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int drops_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  int         m_left = 0;
  bit         m_pend_v = 1'b0;
  logic [3:0] m_pend_row, m_pend_col;
  bit         m_drop = 1'b0;

  function automatic logic [7:0] hex_ch(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  task automatic model_start(input logic [3:0] r, input logic [3:0] c);
    exp_q.push_back(8'h52);
    exp_q.push_back(hex_ch(int'(r)));
    exp_q.push_back(8'h43);
    exp_q.push_back(hex_ch(int'(c)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_left = MSG_CYC;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_left   = 0;
      m_pend_v = 1'b0;
      m_drop   = 1'b0;
    end else begin
      m_drop = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          // message boundary: newest request wins, else the buffered one
          if (tx_start) begin
            m_drop   = m_pend_v;
            m_pend_v = 1'b0;
            model_start(tx_data0, tx_data1);
          end else if (m_pend_v) begin
            m_pend_v = 1'b0;
            model_start(m_pend_row, m_pend_col);
          end
        end else if (tx_start) begin
          m_drop     = m_pend_v;
          m_pend_v   = 1'b1;
          m_pend_row = tx_data0;
          m_pend_col = tx_data1;
        end
      end else if (tx_start) begin
        model_start(tx_data0, tx_data1);
      end
    end
  end

  // Cycle-level checks of busy, drop and line level against the model.
  always @(negedge clk) begin
    if (tx_dropped) drops_seen++;
    if (rst) begin
      check("tx_busy", 32'(tx_busy), 32'(m_left > 0));
      check("tx_dropped", 32'(tx_dropped), 32'(m_drop));
      if (m_left == MSG_CYC) check("start_bit_edge", 32'(uart_tx), 32'd0);
      else if (m_left == 0)  check("idle_line", 32'(uart_tx), 32'd1);
    end
  end

  // ---------------- UART receiver / scoreboard monitor ----------------
  initial begin : rx_mon
    logic [7:0] b;
    logic       stop_bit;
    bit         ok;
    forever begin
      @(negedge clk);
      if (rst && uart_tx == 1'b0) begin
        ok = 1'b1;
        repeat (5) begin @(negedge clk); if (!rst) ok = 1'b0; end
        if (ok && uart_tx != 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (!rst) ok = 1'b0; end
          b[i] = uart_tx;
        end
        repeat (CPB) begin @(negedge clk); if (!rst) ok = 1'b0; end
        stop_bit = uart_tx;
        if (ok) begin
          check("stop_bit", 32'(stop_bit), 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
          end else begin
            check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Call at a negedge: request is sampled at the next posedge.
  task automatic send(input logic [3:0] r, input logic [3:0] c);
    tx_start = 1'b1;
    tx_data0 = r;
    tx_data1 = c;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data0 = 4'($urandom);
    tx_data1 = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy || m_left > 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 5000), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  int d0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_dropped", 32'(tx_dropped), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // basic message and hex letters
    send(4'd2, 4'd3);  wait_idle();
    send(4'hA, 4'hF);  wait_idle();
    send(4'd0, 4'd9);  wait_idle();

    // pending chain at cycle 100 of the first message
    d0 = drops_seen;
    send(4'd1, 4'd1);
    repeat (99) @(negedge clk);
    send(4'd1, 4'd1);
    wait_idle();
    check("chain_no_drop", 32'(drops_seen - d0), 32'd0);

    // overwrite: (4,4) displaced by (5,5)
    d0 = drops_seen;
    send(4'd1, 4'd1);
    repeat (50) @(negedge clk);
    send(4'd4, 4'd4);
    repeat (50) @(negedge clk);
    send(4'd5, 4'd5);
    wait_idle();
    check("overwrite_drops", 32'(drops_seen - d0), 32'd1);

    // request on the last stop-bit cycle, buffer empty: chains, no drop
    d0 = drops_seen;
    send(4'd7, 4'd7);
    repeat (MSG_CYC - 1) @(negedge clk);
    send(4'd7, 4'd7);
    wait_idle();
    check("boundary_empty_drops", 32'(drops_seen - d0), 32'd0);

    // request on the last stop-bit cycle, buffer valid: newest wins, one drop
    d0 = drops_seen;
    send(4'd1, 4'd2);
    repeat (49) @(negedge clk);
    send(4'd3, 4'd4);
    repeat (MSG_CYC - 51) @(negedge clk);
    send(4'd5, 4'd6);
    wait_idle();
    check("boundary_full_drops", 32'(drops_seen - d0), 32'd1);

    // randomized overlapping requests
    for (int k = 0; k < 20; k++) begin
      send(4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 700)) @(negedge clk);
    end
    wait_idle();

    // reset mid-byte: line high at once, message abandoned
    send(4'd8, 4'd8);
    repeat (150) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_line", 32'(uart_tx), 32'd1);
    check("async_reset_busy", 32'(tx_busy), 32'd0);
    check("async_reset_dropped", 32'(tx_dropped), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (700) @(negedge clk);
    check("post_reset_line", 32'(uart_tx), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
